// File: rtl/clksel_seq.sv
// Clock-selection sequencer (lsclk domain). Synchronises the asynchronous
// fast-mode request and the HS-clock feedback, sequences LS <-> HS switches
// through handshake states, enforces a minimum LS dwell, counts completed
// switches and flags transitions that never complete.
module clksel_seq #(
   parameter int SYNC_STAGES   = 2,
   parameter int MIN_LS_CYCLES = 2,
   parameter int TIMEOUT       = 15
) (
   input  logic       lsclk_in,
   input  logic       rst_b,
   input  logic       fast_req_in,
   input  logic       hs_allowed,
   input  logic [1:0] div_sel_cfg,
   input  logic       hsclk_selected,
   input  logic       lsclk_selected,
   input  logic       err_clr,
   output logic       hsclk_sel,
   output logic [1:0] cpuclk_div_sel,
   output logic       busy,
   output logic       err,
   output logic [7:0] sw_count
);

   // bit 0 of the encoding marks the two handshake states, so busy is a
   // plain state-register bit with no decode glitches
   typedef enum logic [1:0] {
      ST_LS    = 2'b00,
      ST_TO_HS = 2'b01,
      ST_HS    = 2'b10,
      ST_TO_LS = 2'b11
   } state_t;

   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
   localparam logic [3:0] DWELL_INIT = 4'(MIN_LS_CYCLES);

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] req_sync_q;
   logic [SYNC_STAGES-1:0] hsok_sync_q;
   logic                   hsclk_sel_q;
   logic [1:0]             div_q;
   logic                   err_q;
   logic [7:0]             sw_count_q;
   logic [7:0]             sw_count_d;
   logic [3:0]             dwell_q;
   logic [7:0]             tcnt_q;
   logic                   req_s;
   logic                   hsok_s;
   logic                   tmo_hit;

   // two-or-more flop synchronisers for the asynchronous request and feedback
   always_ff @(posedge lsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         req_sync_q  <= '0;
         hsok_sync_q <= '0;
      end else begin
         req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], fast_req_in};
         hsok_sync_q <= {hsok_sync_q[SYNC_STAGES-2:0], hsclk_selected};
      end
   end

   assign req_s  = req_sync_q[SYNC_STAGES-1];
   assign hsok_s = hsok_sync_q[SYNC_STAGES-1];

   // timeout compare and saturating switch-count increment
   always_comb begin
      tmo_hit    = (tcnt_q == TMO_LAST);
      sw_count_d = (sw_count_q == 8'hFF) ? sw_count_q : sw_count_q + 8'd1;
   end

   // sequencer FSM with registered select, divider, error and counters
   always_ff @(posedge lsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= ST_LS;
         hsclk_sel_q <= 1'b0;
         div_q       <= 2'b00;
         err_q       <= 1'b0;
         sw_count_q  <= 8'd0;
         dwell_q     <= 4'd0;
         tcnt_q      <= 8'd0;
      end else begin
         if (state_q[0]) tcnt_q <= tcnt_q + 8'd1;
         // a timeout below overrides this clear (set wins)
         if (err_clr) err_q <= 1'b0;
         case (state_q)
            ST_LS: begin
               if (dwell_q != 4'd0) dwell_q <= dwell_q - 4'd1;
               if (req_s && hs_allowed && dwell_q == 4'd0) begin
                  state_q     <= ST_TO_HS;
                  hsclk_sel_q <= 1'b1;
                  // divider only moves while the HS clock is gated off
                  div_q       <= div_sel_cfg;
                  tcnt_q      <= 8'd0;
               end
            end
            ST_TO_HS: begin
               // a dropped request does not abort; finish the switch first
               if (hsok_s) begin
                  state_q    <= ST_HS;
                  sw_count_q <= sw_count_d;
               end else if (tmo_hit) begin
                  state_q     <= ST_LS;
                  hsclk_sel_q <= 1'b0;
                  dwell_q     <= DWELL_INIT;
                  err_q       <= 1'b1;
               end
            end
            ST_HS: begin
               if (!req_s || !hs_allowed) begin
                  state_q     <= ST_TO_LS;
                  hsclk_sel_q <= 1'b0;
                  tcnt_q      <= 8'd0;
               end
            end
            ST_TO_LS: begin
               if (lsclk_selected && !hsok_s) begin
                  state_q <= ST_LS;
                  dwell_q <= DWELL_INIT;
               end else if (tmo_hit) begin
                  state_q <= ST_LS;
                  dwell_q <= DWELL_INIT;
                  err_q   <= 1'b1;
               end
            end
         endcase
      end
   end

   assign hsclk_sel      = hsclk_sel_q;
   assign cpuclk_div_sel = div_q;
   assign busy           = state_q[0];
   assign err            = err_q;
   assign sw_count       = sw_count_q;

endmodule

// File: tb/tb_clksel_seq.sv
// Bench for clksel_seq: timestamp-based behavioural model checked every
// cycle, plus directed literal expectations and randomized traffic.
module tb_clksel_seq;
   localparam int SS    = 2;
   localparam int MINLS = 2;
   localparam int TMO   = 15;

   logic       lsclk_in = 1'b0;
   logic       rst_b = 1'b0;
   logic       fast_req_in = 1'b0;
   logic       hs_allowed = 1'b0;
   logic [1:0] div_sel_cfg = 2'b00;
   logic       hsclk_selected = 1'b0;
   logic       lsclk_selected = 1'b1;
   logic       err_clr = 1'b0;
   logic       hsclk_sel;
   logic [1:0] cpuclk_div_sel;
   logic       busy;
   logic       err;
   logic [7:0] sw_count;

   int vec = 0;
   int miss = 0;
   bit chk_on = 0;
   bit fb_follow = 1;
   bit fb_prev = 0;

   clksel_seq #(.SYNC_STAGES(SS), .MIN_LS_CYCLES(MINLS), .TIMEOUT(TMO)) dut (
      .lsclk_in(lsclk_in), .rst_b(rst_b), .fast_req_in(fast_req_in),
      .hs_allowed(hs_allowed), .div_sel_cfg(div_sel_cfg),
      .hsclk_selected(hsclk_selected), .lsclk_selected(lsclk_selected),
      .err_clr(err_clr), .hsclk_sel(hsclk_sel), .cpuclk_div_sel(cpuclk_div_sel),
      .busy(busy), .err(err), .sw_count(sw_count)
   );

   always #5 lsclk_in = ~lsclk_in;

   task automatic chk(input string nm, input int act, input int exp);
      vec++;
      if (act != exp) begin
         miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---- behavioural model: mode plus edge timestamps of last entries ----
   // mode 0 slow, 1 going fast, 2 fast, 3 going slow
   int   m_mode, m_edge, m_tent, m_lsent, m_cnt;
   logic [1:0] m_div;
   logic m_err;
   bit   rq[$];
   bit   hq[$];

   always @(posedge lsclk_in or negedge rst_b) begin : model
      bit rs, hs, tmo;
      if (!rst_b) begin
         m_mode = 0; m_edge = 0; m_tent = 0; m_lsent = -100; m_cnt = 0;
         m_div = 2'b00; m_err = 1'b0;
         rq = {}; hq = {};
         for (int i = 0; i < SS; i++) begin
            rq.push_back(1'b0);
            hq.push_back(1'b0);
         end
      end else begin
         rs = rq[$]; hs = hq[$]; tmo = 0;
         m_edge++;
         case (m_mode)
            0: if (rs && hs_allowed && (m_edge - m_lsent) > MINLS) begin
                  m_mode = 1; m_tent = m_edge; m_div = div_sel_cfg;
               end
            1: if (hs) begin
                  m_mode = 2;
                  if (m_cnt < 255) m_cnt++;
               end else if (m_edge - m_tent == TMO) begin
                  tmo = 1; m_mode = 0; m_lsent = m_edge;
               end
            2: if (!rs || !hs_allowed) begin
                  m_mode = 3; m_tent = m_edge;
               end
            default: if (lsclk_selected && !hs) begin
                  m_mode = 0; m_lsent = m_edge;
               end else if (m_edge - m_tent == TMO) begin
                  tmo = 1; m_mode = 0; m_lsent = m_edge;
               end
         endcase
         if (tmo) m_err = 1'b1;
         else if (err_clr) m_err = 1'b0;
         rq.push_front(fast_req_in); void'(rq.pop_back());
         hq.push_front(hsclk_selected); void'(hq.pop_back());
      end
   end

   // every-cycle comparison against the model, away from the active edge
   always @(negedge lsclk_in) begin
      if (chk_on) begin
         chk("m_hsclk_sel", int'(hsclk_sel), int'(m_mode == 1 || m_mode == 2));
         chk("m_busy", int'(busy), int'(m_mode == 1 || m_mode == 3));
         chk("m_div", int'(cpuclk_div_sel), int'(m_div));
         chk("m_err", int'(err), int'(m_err));
         chk("m_sw_count", int'(sw_count), m_cnt);
      end
   end

   // controller feedback: follows hsclk_sel one cycle late, or stuck low
   always @(negedge lsclk_in) begin
      if (fb_follow) begin
         hsclk_selected = fb_prev;
         lsclk_selected = !fb_prev;
         fb_prev        = hsclk_sel;
      end else begin
         hsclk_selected = 1'b0;
         lsclk_selected = 1'b0;
      end
   end

   // which: 0 !busy, 1 hsclk_sel, 2 !hsclk_sel, 3 err, 4 settled HS, 5 settled LS
   task automatic wait_cond(input int which, output int n);
      bit ok;
      n = 0; ok = 0;
      while (!ok && n < 200) begin
         @(negedge lsclk_in);
         n++;
         case (which)
            0: ok = !busy;
            1: ok = hsclk_sel;
            2: ok = !hsclk_sel;
            3: ok = err;
            4: ok = hsclk_sel && !busy;
            default: ok = !hsclk_sel && !busy;
         endcase
      end
      if (!ok) begin
         vec++; miss++;
         $display("FAIL wait_%0d: condition not reached within 200 edges", which);
      end
   endtask

   initial begin
      int n;
      repeat (3) @(negedge lsclk_in);
      chk_on = 1;
      chk("rst_hsclk_sel", int'(hsclk_sel), 0);
      chk("rst_div", int'(cpuclk_div_sel), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_sw_count", int'(sw_count), 0);

      // first switch: request latency and ack latency
      rst_b = 1; fast_req_in = 1; hs_allowed = 1; div_sel_cfg = 2'b01;
      for (int k = 1; k <= 7; k++) begin
         @(negedge lsclk_in);
         if (k == 2) chk("req_lat_e2", int'(hsclk_sel), 0);
         if (k == 3) begin
            chk("req_lat_e3", int'(hsclk_sel), 1);
            chk("div_e3", int'(cpuclk_div_sel), 1);
         end
         if (k == 7) begin
            chk("hs_e7_busy", int'(busy), 0);
            chk("hs_e7_cnt", int'(sw_count), 1);
            chk("hs_e7_sel", int'(hsclk_sel), 1);
         end
      end

      // drop latency, then minimum LS residency
      fast_req_in = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge lsclk_in);
         if (k == 2) chk("drop_e2", int'(hsclk_sel), 1);
         if (k == 3) begin
            chk("drop_e3", int'(hsclk_sel), 0);
            chk("drop_e3_busy", int'(busy), 1);
         end
      end
      fast_req_in = 1;
      wait_cond(0, n);
      wait_cond(1, n);
      chk("ls_dwell_edges", n, MINLS + 1);
      wait_cond(4, n);
      fast_req_in = 0;
      wait_cond(5, n);

      // stuck feedback: timeout in TO_HS
      fb_follow = 0; fast_req_in = 1;
      wait_cond(1, n);
      wait_cond(3, n);
      chk("tmo_edges", n, TMO);
      chk("tmo_sel", int'(hsclk_sel), 0);
      chk("tmo_cnt", int'(sw_count), 2);
      fast_req_in = 0; err_clr = 1;
      @(negedge lsclk_in);
      err_clr = 0;
      chk("err_clr", int'(err), 0);
      fb_follow = 1;
      repeat (6) @(negedge lsclk_in);

      // divider held while in HS
      div_sel_cfg = 2'b10; fast_req_in = 1;
      wait_cond(4, n);
      chk("div_hs", int'(cpuclk_div_sel), 2);
      div_sel_cfg = 2'b00;
      repeat (5) @(negedge lsclk_in);
      chk("div_hold0", int'(cpuclk_div_sel), 2);
      div_sel_cfg = 2'b01;
      repeat (3) @(negedge lsclk_in);
      chk("div_hold1", int'(cpuclk_div_sel), 2);
      fast_req_in = 0;
      wait_cond(5, n);
      fast_req_in = 1;
      wait_cond(1, n);
      chk("div_new", int'(cpuclk_div_sel), 1);
      fast_req_in = 0;
      wait_cond(5, n);

      // hs not allowed: no switch despite request
      hs_allowed = 0; fast_req_in = 1;
      repeat (40) @(negedge lsclk_in);
      chk("hs_blocked", int'(hsclk_sel), 0);

      // randomized traffic against the model
      hs_allowed = 1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge lsclk_in);
         if ($urandom_range(0, 7) == 0) fast_req_in = !fast_req_in;
         if ($urandom_range(0, 3) == 0) div_sel_cfg = 2'($urandom_range(0, 3));
         hs_allowed = ($urandom_range(0, 31) != 0);
         err_clr    = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 63) == 0) fb_follow = !fb_follow;
      end
      err_clr = 0; fb_follow = 1; hs_allowed = 1; fast_req_in = 0;
      wait_cond(5, n);
      repeat (8) @(negedge lsclk_in);

      // saturation of the switch counter
      for (int s = 0; s < 300; s++) begin
         fast_req_in = 1;
         wait_cond(4, n);
         fast_req_in = 0;
         wait_cond(5, n);
      end
      chk("sw_sat", int'(sw_count), 255);

      // asynchronous reset while in TO_LS
      fast_req_in = 1;
      wait_cond(4, n);
      fast_req_in = 0;
      wait_cond(2, n);
      chk("to_ls_busy", int'(busy), 1);
      #2 rst_b = 0;
      #1;
      chk("arst_sel", int'(hsclk_sel), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_div", int'(cpuclk_div_sel), 0);
      chk("arst_err", int'(err), 0);
      chk("arst_cnt", int'(sw_count), 0);
      @(negedge lsclk_in);
      rst_b = 1;
      repeat (5) @(negedge lsclk_in);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/clksel_seq.md
# clksel_seq

Clock-selection sequencer in the slow (host) clock domain, directly upstream of the PHI2 clock controller. It turns an asynchronous fast-mode request from the address decoder into a clean, registered `hsclk_sel` and holds the CPU clock divider selection stable. It waits for the controller's selected-clock feedback before declaring each switch complete. It also enforces a minimum low-speed dwell, counts completed switches, and flags any switch that never completes.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops on `fast_req_in` and `hsclk_selected`. Minimum 2.
- `MIN_LS_CYCLES`, default 2: number of lsclk cycles the sequencer stays in LS after a return to slow clock before it may request HS again. Range 0..15.
- `TIMEOUT`, default 15: number of lsclk cycles allowed in a transition state before the error flag is raised. Range 1..255.
- `lsclk_in`  in  1  host slow clock; all state updates on its posedge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `fast_req_in`  in  1  request for high-speed running from the address decode. Asynchronous to lsclk.
- `hs_allowed`  in  1  configuration enable for high-speed mode. Quasi-static and lsclk-synchronous.
- `div_sel_cfg`  in  2  requested CPU clock divider: 00 = /1, 01 = /2, 1x = /4.
- `hsclk_selected`  in  1  controller feedback that the HS clock is running. In the cpuclk domain, so it is synchronised.
- `lsclk_selected`  in  1  controller feedback that the LS clock is running. Already lsclk-posedge registered, so it is used directly.
- `err_clr`  in  1  synchronous clear of `err`.
- `hsclk_sel`  out  1  registered clock-select request to the controller.
- `cpuclk_div_sel`  out  2  registered divider selection to the controller.
- `busy`  out  1  high while in TO_HS or TO_LS.
- `err`  out  1  sticky transition-timeout flag.
- `sw_count`  out  8  count of completed LS-to-HS switches. Saturates at 255.

## Operation
- Synchronisers:
  - `req_s` is `fast_req_in` after SYNC_STAGES flops.
  - `hsok_s` is `hsclk_selected` after SYNC_STAGES flops.
  - Both synchroniser chains reset to 0.
- States: LS, TO_HS, HS, TO_LS. Reset state is LS. The encoding is free.
- LS:
  - `hsclk_sel`=0.
  - While `dwell` > 0, `dwell` decrements by 1 each cycle.
  - LS → TO_HS when `req_s` & `hs_allowed` & `dwell`==0.
  - On that transition edge, `cpuclk_div_sel` ← `div_sel_cfg` and `tcnt` ← 0.
  - `cpuclk_div_sel` changes only on this edge, so the HS clock is gated off whenever it changes.
- TO_HS:
  - `hsclk_sel`=1.
  - TO_HS → HS when `hsok_s`=1. On that edge `sw_count` increments, saturating at 255.
  - A drop of `req_s` in this state does not abort the switch; the sequencer completes to HS first.
- HS:
  - `hsclk_sel`=1.
  - HS → TO_LS when !`req_s` | !`hs_allowed`. On that edge `tcnt` ← 0.
- TO_LS:
  - `hsclk_sel`=0.
  - TO_LS → LS when `lsclk_selected` & !`hsok_s`. On that edge `dwell` ← MIN_LS_CYCLES.
- Timeout:
  - `tcnt` increments each cycle while in TO_HS or TO_LS.
  - When `tcnt` reaches TIMEOUT-1 without the exit condition being met:
    - `err` ← 1.
    - The next state is LS.
    - `hsclk_sel` ← 0.
    - `dwell` ← MIN_LS_CYCLES.
    - `sw_count` is unchanged.
  - If the normal exit condition and the timeout occur in the same cycle, the normal exit wins and `err` is not set.
- `err` clears only on `err_clr`=1 or on reset. If a timeout and `err_clr` occur in the same cycle, set wins.
- `busy` is derived from the state register only, with no combinational path from inputs.

## Timing
- Reset values:
  - State LS.
  - `hsclk_sel`=0, `cpuclk_div_sel`=00, `busy`=0, `err`=0, `sw_count`=0, `dwell`=0, `tcnt`=0.
  - All synchronisers 0.
- Reset is asynchronous. Asserting `rst_b` mid-transition forces LS with `hsclk_sel`=0 immediately, without waiting for a clock edge.
- All outputs are registered on the lsclk posedge.
- Request latency: with `fast_req_in` rising before edge 1, `req_s` is high after edge SYNC_STAGES and `hsclk_sel` is high after edge SYNC_STAGES+1. This is 3 edges at the default parameters.
- HS acknowledge latency: `hsok_s` lags `hsclk_selected` by SYNC_STAGES edges. The state becomes HS one edge after `hsok_s` rises.
- Drop latency: with `fast_req_in` falling, `hsclk_sel` falls after edge SYNC_STAGES+1.
- Minimum LS residency: after entering LS from TO_LS, the earliest re-entry to TO_HS is MIN_LS_CYCLES+1 edges later.
- Timeout fires on the TIMEOUT-th edge spent in a transition state.

## Test plan
- Reset, then `fast_req_in`=1, `hs_allowed`=1, `div_sel_cfg`=01, with `hsclk_selected` following `hsclk_sel` 1 cycle later:
  - `hsclk_sel` rises at edge 3.
  - `cpuclk_div_sel`=01 from edge 3.
  - State is HS, `busy`=0 and `sw_count`=1 by edge 7.
- In HS, drop `fast_req_in` and let the feedback follow:
  - `hsclk_sel` falls at edge 3.
  - The next request is accepted no earlier than 3 edges after LS re-entry (MIN_LS_CYCLES=2).
- Hold `hsclk_selected`=0 in TO_HS:
  - `err`=1 on the 15th edge.
  - `hsclk_sel`=0 and `sw_count` unchanged.
  - `err_clr` pulse returns `err` to 0.
- Change `div_sel_cfg` while in HS: `cpuclk_div_sel` is unchanged until the next LS → TO_HS transition.
- `hs_allowed`=0 with `fast_req_in`=1: `hsclk_sel` stays 0 indefinitely. Also run 300 complete switches and check `sw_count` saturates at 255.
- Assert `rst_b` low while in TO_LS: all outputs return to their reset values asynchronously.
